// File: rtl/alu_arbiter_pkg.sv
// Operand and operation types shared by the calculator datapath.
package alu_arbiter_pkg;

  typedef logic [31:0] num_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-port request/response bundle between requesters and the ALU arbiter.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  num_t [1:0] req_left;
  num_t [1:0] req_right;
  op_t  [1:0] req_op;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  num_t       rsp_data;

  modport master (
    output req_valid, req_left, req_right, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_left, req_right, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one fixed-latency ALU between two requesters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned AluLatency = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave arb_io,
  output num_t         alu_left_o,
  output num_t         alu_right_o,
  output op_t          alu_op_o,
  input  num_t         alu_result_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] sync_q;
  logic       rst_n;
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  num_t       left_q, left_d;
  num_t       right_q, right_d;
  num_t       data_q, data_d;
  op_t        op_q, op_d;
  logic       win;
  logic [1:0] ready;
  logic       accept;

  // Assert passes straight through; release waits two clock edges.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_n = sync_q[1];

  assign win = (&arb_io.req_valid) ? ~last_q
             : arb_io.req_valid[1];

  assign ready = (rst_n && state_q == IDLE &&
                  arb_io.req_valid[win])
               ? (2'b01 << win) : 2'b00;

  assign accept = |(arb_io.req_valid & ready);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      op_q    <= OP_ADD;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    right_d = right_q;
    op_d    = op_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          last_d  = win;
          owner_d = win;
          cnt_d   = 4'(AluLatency);
          left_d  = arb_io.req_left[win];
          right_d = arb_io.req_right[win];
          op_d    = arb_io.req_op[win];
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          data_d  = alu_result_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (arb_io.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb_io.req_ready = ready;
  assign arb_io.rsp_valid = (state_q == RESP)
                          ? (2'b01 << owner_q) : 2'b00;
  assign arb_io.rsp_data  = data_q;
  assign alu_left_o       = left_q;
  assign alu_right_o      = right_q;
  assign alu_op_o         = op_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration, backpressure,
// latency sweep, withdrawn requests and reset mid-operation.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam logic [3:0][3:0] LATS = {4'd15, 4'd4, 4'd1, 4'd0};

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   waited;

  always #5 clk = ~clk;

  function automatic num_t alu_f(op_t op, num_t l, num_t r);
    case (op)
      OP_ADD:  return l + r;
      OP_SUB:  return l - r;
      OP_MUL:  return l * r;
      default: return (r == 0) ? '0 : l / r;
    endcase
  endfunction

  alu_arbiter_if bus ();
  num_t m_left, m_right, m_res_q;
  op_t  m_op;
  logic m_busy;

  always_ff @(posedge clk) m_res_q <= alu_f(m_op, m_left, m_right);

  alu_arbiter #(.AluLatency(1)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .arb_io      (bus),
    .alu_left_o  (m_left),
    .alu_right_o (m_right),
    .alu_op_o    (m_op),
    .alu_result_i(m_res_q),
    .busy_o      (m_busy)
  );

  logic [1:0] sw_valid;
  logic [1:0] sw_rsp_ready;
  num_t [1:0] sw_left;
  num_t [1:0] sw_right;
  op_t  [1:0] sw_op;
  logic [1:0] sw_req_ready [4];
  logic [1:0] sw_rsp_valid [4];
  num_t       sw_rsp_data  [4];
  logic       sw_busy      [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int L   = int'(LATS[g]);
    localparam int IDX = (L == 0) ? 0 : L - 1;
    alu_arbiter_if sbus ();
    num_t a_l, a_r, res;
    op_t  a_op;
    num_t pipe_q [16];

    assign sbus.req_valid = sw_valid;
    assign sbus.req_left  = sw_left;
    assign sbus.req_right = sw_right;
    assign sbus.req_op    = sw_op;
    assign sbus.rsp_ready = sw_rsp_ready;
    assign sw_req_ready[g] = sbus.req_ready;
    assign sw_rsp_valid[g] = sbus.rsp_valid;
    assign sw_rsp_data[g]  = sbus.rsp_data;

    always_ff @(posedge clk) begin
      pipe_q[0] <= alu_f(a_op, a_l, a_r);
      for (int i = 1; i < 16; i++) pipe_q[i] <= pipe_q[i-1];
    end

    assign res = (L == 0) ? alu_f(a_op, a_l, a_r) : pipe_q[IDX];

    alu_arbiter #(.AluLatency(L)) u_sw (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .arb_io      (sbus),
      .alu_left_o  (a_l),
      .alu_right_o (a_r),
      .alu_op_o    (a_op),
      .alu_result_i(res),
      .busy_o      (sw_busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int p, input num_t l, input num_t r,
                     input op_t op);
    bus.req_left[p]  = l;
    bus.req_right[p] = r;
    bus.req_op[p]    = op;
    bus.req_valid[p] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_left  = '0;
    bus.req_right = '0;
    bus.req_op[0] = OP_ADD;
    bus.req_op[1] = OP_ADD;
    bus.rsp_ready = 2'b11;
    sw_valid = 2'b00;
    sw_left  = '0;
    sw_right = '0;
    sw_op[0] = OP_ADD;
    sw_op[1] = OP_ADD;
    sw_rsp_ready = 2'b11;

    // Reset values, with requests pending.
    cyc(); cyc();
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_alu_left", m_left, 0);
    chk("rst_alu_right", m_right, 0);
    chk("rst_alu_op", m_op, 0);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (3) cyc();

    // Contention: grants alternate 0,1,0,1.
    put(0, 10, 3, OP_SUB);
    put(1, 6, 4, OP_MUL);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] oh;
      num_t       ev;
      oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      ev = (i % 2 == 0) ? 32'd7 : 32'd24;
      #1;
      chk($sformatf("cont_grant_%0d", i), bus.req_ready, oh);
      cyc();
      chk("cont_wait_ready", bus.req_ready, 2'b00);
      chk("cont_wait_busy", m_busy, 1'b1);
      cyc(); cyc();
      chk("cont_resp_ready", bus.req_ready, 2'b00);
      chk($sformatf("cont_rsp_valid_%0d", i), bus.rsp_valid, oh);
      chk($sformatf("cont_rsp_data_%0d", i), bus.rsp_data, ev);
      cyc();
    end
    bus.req_valid = 2'b00;

    // Single request on port 0: 7 + 5.
    put(0, 7, 5, OP_ADD);
    #1;
    chk("single_ready", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    chk("single_busy", m_busy, 1'b1);
    chk("single_alu_left", m_left, 7);
    chk("single_alu_right", m_right, 5);
    chk("single_alu_op", m_op, OP_ADD);
    cyc();
    chk("single_no_early_rsp", bus.rsp_valid, 2'b00);
    cyc();
    chk("single_rsp_valid", bus.rsp_valid, 2'b01);
    chk("single_rsp_data", bus.rsp_data, 12);
    cyc();
    chk("single_idle", m_busy, 1'b0);
    chk("single_rsp_drop", bus.rsp_valid, 2'b00);
    chk("single_data_hold", bus.rsp_data, 12);
    chk("single_alu_hold", m_left, 7);

    // Backpressure on port 1 while port 0 keeps asking.
    bus.rsp_ready = 2'b01;
    put(0, 1, 1, OP_ADD);
    put(1, 9, 2, OP_DIV);
    #1;
    chk("bp_grant", bus.req_ready, 2'b10);
    cyc();
    bus.req_valid[1] = 1'b0;
    cyc(); cyc();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_rsp_valid_%0d", k), bus.rsp_valid, 2'b10);
      chk($sformatf("bp_rsp_data_%0d", k), bus.rsp_data, 4);
      chk($sformatf("bp_req_ready_%0d", k), bus.req_ready, 2'b00);
      cyc();
    end
    bus.rsp_ready[1] = 1'b1;
    #1;
    chk("bp_still_resp", bus.rsp_valid, 2'b10);
    cyc();
    chk("bp_idle", m_busy, 1'b0);
    chk("bp_rsp_drop", bus.rsp_valid, 2'b00);
    chk("bp_next_grant", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid[0] = 1'b0;
    cyc(); cyc();
    chk("bp_p0_rsp_valid", bus.rsp_valid, 2'b01);
    chk("bp_p0_rsp_data", bus.rsp_data, 2);
    cyc();

    // Port 1 pulses valid while busy, then withdraws.
    put(0, 20, 22, OP_ADD);
    #1;
    chk("wd_p0_grant", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid[0] = 1'b0;
    put(1, 99, 1, OP_SUB);
    #1;
    chk("wd_no_grant_busy", bus.req_ready, 2'b00);
    cyc();
    bus.req_valid[1] = 1'b0;
    cyc();
    chk("wd_p0_rsp_valid", bus.rsp_valid, 2'b01);
    chk("wd_p0_rsp_data", bus.rsp_data, 42);
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wd_no_rsp_%0d", k), bus.rsp_valid, 2'b00);
      chk($sformatf("wd_idle_%0d", k), m_busy, 1'b0);
      cyc();
    end

    // Latency sweep: 100+23 primes the ALU models, then 50-8.
    sw_left[0]  = 100;
    sw_right[0] = 23;
    sw_op[0]    = OP_ADD;
    sw_valid    = 2'b01;
    #1;
    for (int g = 0; g < 4; g++)
      chk($sformatf("sw_grant_%0d", g), sw_req_ready[g], 2'b01);
    cyc();
    sw_valid = 2'b00;
    repeat (20) cyc();
    sw_left[0]  = 50;
    sw_right[0] = 8;
    sw_op[0]    = OP_SUB;
    sw_valid    = 2'b01;
    cyc();
    sw_valid     = 2'b00;
    sw_rsp_ready = 2'b00;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      for (int g = 0; g < 4; g++) begin
        int lat;
        lat = int'(LATS[g]);
        chk($sformatf("sw_valid_L%0d_k%0d", lat, k),
            sw_rsp_valid[g], (k > lat) ? 2'b01 : 2'b00);
        if (k == lat + 1)
          chk($sformatf("sw_data_L%0d", lat), sw_rsp_data[g], 42);
      end
    end
    sw_rsp_ready = 2'b11;
    cyc();
    for (int g = 0; g < 4; g++)
      chk($sformatf("sw_idle_%0d", g), sw_busy[g], 1'b0);

    // Reset one cycle after accept.
    put(0, 3, 4, OP_MUL);
    #1;
    chk("rr_grant", bus.req_ready, 2'b01);
    cyc();
    bus.req_valid[0] = 1'b0;
    chk("rr_busy_before", m_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rr_busy", m_busy, 1'b0);
    chk("rr_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rr_rsp_data", bus.rsp_data, 0);
    chk("rr_alu_left", m_left, 0);
    chk("rr_alu_right", m_right, 0);
    chk("rr_alu_op", m_op, 0);
    put(0, 5, 5, OP_ADD);
    put(1, 6, 6, OP_ADD);
    #1;
    chk("rr_req_ready", bus.req_ready, 2'b00);
    cyc(); cyc();
    rst_n = 1'b1;
    waited = 0;
    while (bus.req_ready == 2'b00 && waited < 6) begin
      chk("rr_no_rsp", bus.rsp_valid, 2'b00);
      cyc();
      waited++;
    end
    chk("rr_first_grant", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single calculator `alu` between two requesters: port 0 is the main `controller` and port 1 is an auxiliary sequencer such as memory recall or repeat-equals. Each port issues one operation through a valid/ready request handshake and receives its result through a valid/ready response handshake. The block arbitrates round-robin, drives the ALU operand and op inputs from registered copies, waits a fixed ALU latency, then captures and returns the result. It sits between the requesters and `alu` inside `calculator`.

## Interface
- `AluLatency`, default 1: edges from ALU inputs being stable to `alu_result_i` being valid. Legal range is 0–15.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  2  per-port request valid.
- `req_ready_o`  out  2  per-port request ready.
- `req_left_i`  in  2×num_t  per-port left operand.
- `req_right_i`  in  2×num_t  per-port right operand.
- `req_op_i`  in  2×op_t  per-port operation.
- `rsp_valid_o`  out  2  per-port response valid.
- `rsp_ready_i`  in  2  per-port response ready.
- `rsp_data_o`  out  num_t  captured result, shared by both ports.
- `alu_left_o`  out  num_t  ALU left operand.
- `alu_right_o`  out  num_t  ALU right operand.
- `alu_op_o`  out  op_t  ALU operation.
- `alu_result_i`  in  num_t  ALU result.
- `busy_o`  out  1  high whenever the block is not in IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready_o` is one-hot on the arbitration winner, and only when that port's `req_valid_i` is high. Otherwise it is 0.
  - Winner: the requesting port not granted last time. With a single requester, that requester wins.
  - Accept is `req_valid_i[w] & req_ready_o[w]`. On accept:
    - latch left, right and op into the ALU output registers;
    - record the owner w and flip the last-grant pointer to w;
    - load the counter with `AluLatency`;
    - go to WAIT.
- **WAIT**
  - The ALU outputs hold the latched values.
  - The counter decrements each edge.
  - On the edge where the counter equals 0: capture `alu_result_i` into `rsp_data_o` and go to RESP.
- **RESP**
  - `rsp_valid_o[owner]` is high. The other bit is 0.
  - When `rsp_ready_i[owner]` is high: return to IDLE on that edge.
  - Otherwise hold indefinitely.
  - `rsp_ready_i` of the non-owner is ignored.
- `req_ready_o` is 0 in WAIT and RESP. Requests stay pending and are not lost.
- A requester may drop `req_valid_i` before acceptance. Nothing is committed.
- Request fields must be stable only during the accept cycle.
- `rsp_data_o` holds the last captured value until the next capture.
- ALU outputs hold the last issued values in IDLE.
- No arithmetic is done here. Widths pass through as num_t and op_t unchanged.

## Timing
- Reset values: state IDLE; `req_ready_o`=0, `rsp_valid_o`=0, `busy_o`=0; `rsp_data_o`=0, `alu_left_o`=0, `alu_right_o`=0; `alu_op_o` = op_t encoding 0; last-grant pointer = 1, so port 0 wins the first contention.
- Accept at edge E0:
  - ALU outputs are valid from E0.
  - Capture happens at edge E0+AluLatency+1.
  - `rsp_valid_o` is high from that edge.
  - With `AluLatency`=1 and `rsp_ready` already high, `rsp_valid` is high in the 2nd cycle after E0 and IDLE is re-entered at E0+3.
- Minimum issue interval per port and overall: `AluLatency`+3 edges.
- `req_ready_o` is a combinational function of state, pointer and `req_valid_i`. It has no dependency on `rsp_ready_i`.
- Simultaneous requests in IDLE: exactly one grant, the winner going by the pointer. The loser is granted on the next IDLE if it is still valid, so neither port starves.
- The response handshake and a new request on the same edge cannot overlap, because RESP→IDLE costs one edge.
- Reset asserted mid-operation:
  - The in-flight op is discarded and no response is produced.
  - All outputs take their reset values immediately (asynchronous).
  - Release is synchronous to `clk_i` through the standard reset synchroniser.

## Test plan
- Single request: port 0 sends left=7, right=5, op=add, with `AluLatency`=1 and the ALU model returning 12. Required: `req_ready_o[0]` high at the accept cycle, `rsp_valid_o`=2'b01 with `rsp_data_o`=12 two cycles after accept, `busy_o` low again 3 edges after accept.
- Contention: both ports valid continuously out of reset. Required: grants alternate 0,1,0,1; each response is tagged to the correct port; no grant is issued while `busy_o`=1.
- Response backpressure: `rsp_ready_i[1]` is held low for 5 cycles. Required: `rsp_valid_o[1]` and `rsp_data_o` are stable all 5 cycles, `req_ready_o`=0 throughout, IDLE is entered on the edge after ready rises, and `rsp_ready_i[0]` is ignored.
- Latency sweep: `AluLatency` in {0,1,4,15} with an ALU model that delays its result by `AluLatency` edges. Required: capture at E0+`AluLatency`+1, checked by comparing `rsp_data_o` against the model.
- Withdrawn request: port 1 pulses valid for one cycle while busy, then drops it. Required: port 1 is never granted and no response is issued for it.
- Reset mid-WAIT: assert `rst_i` low one cycle after accept. Required: all outputs are at reset values the same cycle, no `rsp_valid_o` after release, and port 0 wins the next contention.
